// File: rtl/sdm_audio_out.sv
// Multi-channel delta-sigma audio output: paced frame intake, mute/volume, 1st/2nd-order modulators.
// Optional TPDF-style LSB dither is enabled by defining SDM_DITHER_EN.
module sdm_audio_out #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ORDER    = 2,
    parameter int unsigned OSR      = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CHANNELS*WIDTH-1:0] s_data,
    input  logic                      mute,
    input  logic [2:0]                vol_shift,
    output logic [7:0]                underrun_cnt,
    output logic [CHANNELS-1:0]       pwm_out
);

    localparam int unsigned CW  = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int unsigned FW  = CHANNELS * WIDTH;
    localparam int unsigned V1W = WIDTH + 2;
    localparam int unsigned S1W = V1W + 2;

    localparam logic signed [S1W-1:0] Y1P    = S1W'(1) << (WIDTH - 1);
    localparam logic signed [S1W-1:0] V1_MAX = (S1W'(1) << (V1W - 1)) - S1W'(1);
    localparam logic signed [S1W-1:0] V1_MIN = -(S1W'(1) << (V1W - 1));

    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [FW-1:0]       hold_q, hold_d;
    logic [FW-1:0]       active_q, active_d;
    logic [7:0]          urun_q, urun_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                tick;

    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
        $error("sdm_audio_out: ORDER must be 1 or 2");
    end

    assign tick         = (cnt_q == CW'(OSR - 1));
    assign s_ready      = ready_q;
    assign underrun_cnt = urun_q;
    assign pwm_out      = pwm_q;

    // Frame intake, pacing and underrun accounting
    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        ready_d  = ready_q;
        hold_d   = hold_q;
        active_d = active_q;
        urun_d   = urun_q;
        if (tick) begin
            if (!ready_q) begin
                active_d = hold_q;
                ready_d  = 1'b1;
            end else if (urun_q != 8'hFF) begin
                urun_d = urun_q + 8'd1;
            end
        end
        if (s_valid && ready_q) begin
            hold_d  = s_data;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            hold_q   <= '0;
            active_q <= '0;
            urun_q   <= '0;
            pwm_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            hold_q   <= hold_d;
            active_q <= active_d;
            urun_q   <= urun_d;
            pwm_q    <= pwm_d;
        end
    end

`ifdef SDM_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // x^16 + x^14 + x^13 + x^11 + 1, shared by all channels
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hFFFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic signed [WIDTH-1:0] act, sh, xs, xin;
        logic signed [S1W-1:0]   y1, s1;
        logic signed [V1W-1:0]   v1_q, v1_d;

        assign act = active_q[k*WIDTH +: WIDTH];
        assign sh  = act >>> vol_shift;
        assign xs  = mute ? '0 : sh;

`ifdef SDM_DITHER_EN
        localparam logic signed [WIDTH-1:0] XMAX = {1'b0, {(WIDTH-1){1'b1}}};
        localparam logic signed [WIDTH-1:0] XMIN = {1'b1, {(WIDTH-1){1'b0}}};

        // +/-1 LSB dither, held back at the rails so the input stays in range
        always_comb begin
            xin = xs;
            if (lfsr_q[0]) begin
                if (xs != XMAX) xin = xs + WIDTH'(1);
            end else begin
                if (xs != XMIN) xin = xs - WIDTH'(1);
            end
        end
`else
        assign xin = xs;
`endif

        assign y1   = pwm_q[k] ? Y1P : -Y1P;
        assign s1   = S1W'(v1_q) + S1W'(xin) - y1;
        assign v1_d = (s1 > V1_MAX) ? V1W'(V1_MAX) :
                      (s1 < V1_MIN) ? V1W'(V1_MIN) : V1W'(s1);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1_q <= '0;
            end else begin
                v1_q <= v1_d;
            end
        end

        if (ORDER == 1) begin : g_o1
            assign pwm_d[k] = ~v1_d[V1W-1];
        end else begin : g_o2
            localparam int unsigned V2W = WIDTH + 4;
            localparam int unsigned S2W = V2W + 2;
            localparam logic signed [S2W-1:0] Y2P    = S2W'(1) << (WIDTH - 1);
            localparam logic signed [S2W-1:0] V2_MAX = (S2W'(1) << (V2W - 1)) - S2W'(1);
            localparam logic signed [S2W-1:0] V2_MIN = -(S2W'(1) << (V2W - 1));

            logic signed [S2W-1:0] y2, s2;
            logic signed [V2W-1:0] v2_q, v2_d;

            // Second integrator is fed by the updated first integrator (CIFB)
            assign y2   = pwm_q[k] ? Y2P : -Y2P;
            assign s2   = S2W'(v2_q) + S2W'(v1_d) - y2;
            assign v2_d = (s2 > V2_MAX) ? V2W'(V2_MAX) :
                          (s2 < V2_MIN) ? V2W'(V2_MIN) : V2W'(s2);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2_q <= '0;
                end else begin
                    v2_q <= v2_d;
                end
            end

            assign pwm_d[k] = ~v2_d[V2W-1];
        end
    end

endmodule

// File: tb/tb_sdm_audio_out.sv
// Directed self-checking bench for sdm_audio_out (WIDTH=16, CHANNELS=2, ORDER=2, OSR=256).
module tb_sdm_audio_out;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        mute;
    logic [2:0]  vol_shift;
    logic [7:0]  underrun_cnt;
    logic [1:0]  pwm_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sdm_audio_out #(
        .WIDTH    (16),
        .CHANNELS (2),
        .ORDER    (2),
        .OSR      (256)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .mute         (mute),
        .vol_shift    (vol_shift),
        .underrun_cnt (underrun_cnt),
        .pwm_out      (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of posedges since the last reset release; sampling on negedges
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    task automatic count_ones(input int n, output int o0, output int o1);
        o0 = 0;
        o1 = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            o0 += int'(pwm_out[0]);
            o1 += int'(pwm_out[1]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", s_ready);
        end
        checks++;
        if (underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_underrun got=%0d want=0", underrun_cnt);
        end
        checks++;
        if (pwm_out !== 2'b00) begin
            failures++;
            $display("FAIL reset_pwm got=%b want=00", pwm_out);
        end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_muted_idle();
        logic [7:0] pat;
        int o0, o1, a, b;
        // x=0 from zero state: 1,1,0,1 then period 0,0,1,1
        pat = 8'b11001011;
        o0  = 0;
        o1  = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            checks++;
            if (pwm_out !== {pat[i], pat[i]}) begin
                failures++;
                $display("FAIL muted_pattern cycle=%0d got=%b want=%b", cyc, pwm_out, {pat[i], pat[i]});
            end
            o0 += int'(pwm_out[0]);
            o1 += int'(pwm_out[1]);
        end
        count_ones(247, a, b);
        o0 += a;
        o1 += b;
        checks++;
        if (underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL underrun_before_first_tick got=%0d want=0", underrun_cnt);
        end
        count_ones(1, a, b);
        o0 += a;
        o1 += b;
        checks++;
        if (underrun_cnt !== 8'd1) begin
            failures++;
            $display("FAIL underrun_first_tick got=%0d want=1", underrun_cnt);
        end
        count_ones(4096 - 256, a, b);
        o0 += a;
        o1 += b;
        checks++;
        if (o0 < 2044 || o0 > 2052) begin
            failures++;
            $display("FAIL muted_ones_ch0 got=%0d want=2048+-4", o0);
        end
        checks++;
        if (o1 < 2044 || o1 > 2052) begin
            failures++;
            $display("FAIL muted_ones_ch1 got=%0d want=2048+-4", o1);
        end
        checks++;
        if (underrun_cnt !== 8'd16) begin
            failures++;
            $display("FAIL muted_underrun got=%0d want=16", underrun_cnt);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 2'b00) begin
            failures++;
            $display("FAIL midreset_pwm got=%b want=00", pwm_out);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready got=%b want=1", s_ready);
        end
        checks++;
        if (underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL midreset_underrun got=%0d want=0", underrun_cnt);
        end
        mute      = 1'b0;
        vol_shift = 3'd0;
        s_data    = {16'hC000, 16'h4000};
        s_valid   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_handshake();
        int acc, bad;
        logic exp;
        acc = 0;
        bad = 0;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL hs_ready_initial got=%b want=1", s_ready);
        end
        for (int c = 0; c < 2048; c++) begin
            if (s_valid && s_ready) acc++;
            step(1);
            exp = ((cyc % 256) == 0);
            if (s_ready !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hs_ready_pattern bad_cycles=%0d want=0", bad);
        end
        checks++;
        if (acc != 8) begin
            failures++;
            $display("FAIL hs_accept_count got=%0d want=8", acc);
        end
        checks++;
        if (underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL hs_underrun got=%0d want=0", underrun_cnt);
        end
    endtask

    task automatic test_dc_tracking();
        int o0, o1;
        step(512);
        count_ones(4096, o0, o1);
        checks++;
        if (o0 < 3052 || o0 > 3092) begin
            failures++;
            $display("FAIL dc_ones_ch0 got=%0d want=3072+-20", o0);
        end
        checks++;
        if (o1 < 1004 || o1 > 1044) begin
            failures++;
            $display("FAIL dc_ones_ch1 got=%0d want=1024+-20", o1);
        end
        checks++;
        if (underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL dc_underrun got=%0d want=0", underrun_cnt);
        end
    endtask

    task automatic test_volume();
        int o0, o1;
        vol_shift = 3'd2;
        step(512);
        count_ones(4096, o0, o1);
        checks++;
        if (o0 < 2284 || o0 > 2324) begin
            failures++;
            $display("FAIL vol_ones_ch0 got=%0d want=2304+-20", o0);
        end
        checks++;
        if (o1 < 1772 || o1 > 1812) begin
            failures++;
            $display("FAIL vol_ones_ch1 got=%0d want=1792+-20", o1);
        end
    endtask

    task automatic test_full_scale();
        int o0, o1;
        vol_shift = 3'd0;
        s_data    = {16'h8000, 16'h7FFF};
        step(768);
        count_ones(4096, o0, o1);
        checks++;
        if (o0 < 4092) begin
            failures++;
            $display("FAIL fs_pos_ones got=%0d want>=4092", o0);
        end
        checks++;
        if (o1 > 4) begin
            failures++;
            $display("FAIL fs_neg_ones got=%0d want<=4", o1);
        end
        checks++;
        if (underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL fs_underrun got=%0d want=0", underrun_cnt);
        end
    endtask

    task automatic test_underrun();
        int o0, o1, t;
        step(8);
        s_valid = 1'b0;
        t = (cyc / 256 + 1) * 256;
        step(t - cyc);
        checks++;
        if (underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL ur_pending_consumed got=%0d want=0", underrun_cnt);
        end
        count_ones(4096, o0, o1);
        checks++;
        if (o0 < 4092) begin
            failures++;
            $display("FAIL ur_hold_ch0 got=%0d want>=4092", o0);
        end
        checks++;
        if (o1 > 4) begin
            failures++;
            $display("FAIL ur_hold_ch1 got=%0d want<=4", o1);
        end
        checks++;
        if (underrun_cnt !== 8'd16) begin
            failures++;
            $display("FAIL ur_count16 got=%0d want=16", underrun_cnt);
        end
        step(238 * 256);
        checks++;
        if (underrun_cnt !== 8'd254) begin
            failures++;
            $display("FAIL ur_count254 got=%0d want=254", underrun_cnt);
        end
        step(256);
        checks++;
        if (underrun_cnt !== 8'd255) begin
            failures++;
            $display("FAIL ur_count255 got=%0d want=255", underrun_cnt);
        end
        step(512);
        checks++;
        if (underrun_cnt !== 8'd255) begin
            failures++;
            $display("FAIL ur_saturate got=%0d want=255", underrun_cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        mute      = 1'b1;
        vol_shift = 3'd0;
        test_reset();
        test_muted_idle();
        test_reset_mid();
        test_handshake();
        test_dc_tracking();
        test_volume();
        test_full_scale();
        test_underrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdm_audio_out.md
# sdm_audio_out

Multi-channel delta-sigma audio DAC front end: accepts frames of signed PCM samples over a valid/ready handshake, paces them at a fixed oversampling ratio, applies mute and shift-based attenuation, and drives one 1-bit pulse-density output per channel. It is the parametrised successor to the single-channel first-order PWM output. It adds selectable 1st/2nd-order noise shaping, integrator saturation, input buffering with backpressure, and underrun accounting. It sits between the audio sample source and the board's RC-filtered output pins.

## Interface
- `WIDTH`, 16: sample width, signed two's complement.
- `CHANNELS`, 2: number of independent modulators.
- `ORDER`, 2: modulator order, 1 or 2; any other value is a synthesis error.
- `OSR`, 256: clk cycles per consumed frame, ≥ 4.
- `clk` in 1: modulator and control clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: input frame valid.
- `s_ready` out 1: frame holding register empty.
- `s_data` in `CHANNELS*WIDTH`: frame; channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `mute` in 1: forces modulator input to zero, all channels.
- `vol_shift` in 3: arithmetic right-shift attenuation, 0–7.
- `underrun_cnt` out 8: saturating count of ticks with no frame pending.
- `pwm_out` out `CHANNELS`: registered 1-bit density outputs.

## Operation
- **Holding register `hold` and flag `full`**
  - `s_ready = !full`.
  - When `s_valid && s_ready`: `hold <= s_data` and `full <= 1`.
- **Tick counter**
  - Counts 0..OSR-1 and wraps.
  - `tick` asserts when the count equals OSR-1.
  - At `tick` with `full`: `active <= hold` and `full <= 0`.
  - At `tick` with `!full`: `active` is unchanged (last frame repeats), and `underrun_cnt` increments, saturating at 255.
- **Modulator input, per channel**
  - `x = mute ? 0 : (active_k >>> vol_shift)`.
  - Combinational from the current `mute` and `vol_shift`, so changes take effect on the next modulator update.
- **Feedback**
  - `y = pwm_out_k ? +2^(WIDTH-1) : -2^(WIDTH-1)`.
- **ORDER=1**
  - `v1 <= sat(v1 + x - y)`, width WIDTH+2.
  - `pwm_out_k <= (next v1 >= 0)`.
- **ORDER=2 (CIFB)**
  - `v1 <= sat(v1 + x - y)`, width WIDTH+2.
  - `v2 <= sat(v2 + next_v1 - y)`, width WIDTH+4.
  - `pwm_out_k <= (next v2 >= 0)`.
- **Saturation:** `sat()` clamps to the signed range of the destination integrator. Integrators never wrap.
- **Duty cycle:** the long-run fraction of 1s is `(x + 2^(WIDTH-1)) / 2^WIDTH`.
- **Channel independence:** channels update in parallel every cycle; there is no time-multiplexing.

## Timing
- **Reset values:**
  - `s_ready = 1`, `underrun_cnt = 0`, `pwm_out = 0`.
  - Tick counter 0; `hold`, `active`, and all integrators 0.
  - `full = 0`; LFSR seeded with the all-ones pattern.
- **Reset mid-operation:** all state returns to the reset values immediately; any pending frame is discarded.
- **Backpressure:** `s_ready` falls the cycle after acceptance and rises the cycle after the next `tick`. At most one frame is accepted per tick period.
- **Acceptance and tick in the same cycle:** cannot occur while `full`, because `s_ready` is low. When `!full` at a tick, the underrun is counted and the accepted frame waits for the following tick.
- **Latency:**
  - Frame accepted at cycle t reaches `active` at the first tick after t.
  - It influences `pwm_out` one cycle after that tick.
- **`underrun_cnt`:** clears only on reset.
- **First tick after reset:** counts as an underrun if no frame has been accepted.

## Configuration
- **`SDM_DITHER_EN` defined:**
  - A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1) advances every cycle.
  - LFSR bit 0 adds +1 LSB or -1 LSB to every channel's `x` before the integrator.
  - If `x` is already at its extreme, the dither is clamped so the input never exceeds the WIDTH range.
  - Dither is applied even while `mute` is asserted.
- **Undefined:** no LFSR is instantiated and `x` is used unmodified. Behaviour is otherwise bit-identical.

## Test plan
All scenarios use WIDTH=16, CHANNELS=2, OSR=256.
- **Muted idle:** after reset, `mute=1`, ORDER=2, 4096 cycles → `pwm_out` 1-count per channel 2048±4, and `underrun_cnt` counts ticks up to 16.
- **DC tracking:** frames ch0=+16384, ch1=-16384 streamed continuously → over 8192 cycles, ch0 ones fraction 0.75±0.005, ch1 0.25±0.005, and `underrun_cnt` stays at its post-start value.
- **Handshake timing:** `s_valid` held high → exactly one acceptance per 256 cycles; `s_ready` low for the cycles from acceptance+1 up to tick; `active` updates on the tick only.
- **Underrun hold and saturation:** stream stops for 300 ticks → `active` holds its last value and `underrun_cnt` saturates at 255.
- **Full-scale input:** +32767 on ORDER=2 for 65536 cycles → no integrator wrap; ones fraction ≥ 0.999. Then -32768 → ≤ 0.001.
- **Volume and reset:** `vol_shift=2` on +16384 → ones fraction 0.5625±0.005. Mid-stream `rst_n` pulse → all outputs at reset values the same cycle and `s_ready=1`.
